// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: frame states, error codes,
// byte width and the frame checksum helper.
package uart_cmd_decoder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_ARG = 2'd1,
    WAIT_CHK = 2'd2,
    ISSUE    = 2'd3
  } dec_state_t;

  localparam logic [1:0] ERR_LINE     = 2'b00;
  localparam logic [1:0] ERR_UNKNOWN  = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Checksum byte that must follow CMD and ARG.
  function automatic logic [BYTE_W-1:0] frame_chk(input logic [BYTE_W-1:0] cmd,
                                                  input logic [BYTE_W-1:0] arg);
    return cmd ^ arg;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_gap_timer.sv
// Inter-byte gap timer. The counter is zeroed on the edge that accepts a byte,
// so during the k-th cycle after that byte it holds k-1. 'expired' is raised in
// the cycle whose closing edge is the TIMEOUT_CYCLES-1-th after the byte; a byte
// sampled on that same edge still wins (the decoder checks rx_done first).
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = enable && (count_q == LAST);

  // Next count: clear wins, otherwise count while enabled and park at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles CMD/ARG/CHK frames from the UART receiver byte stream, validates
// them and hands one command at a time to the control logic over valid/ready.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_CMDS       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_error,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_code,
  output logic [BYTE_W-1:0] cmd_arg,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [7:0]        drop_cnt
);

  dec_state_t        state_q, state_d;
  logic [BYTE_W-1:0] cmd_byte_q, cmd_byte_d;
  logic [BYTE_W-1:0] arg_byte_q, arg_byte_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [3:0]        cmd_code_q, cmd_code_d;
  logic [BYTE_W-1:0] cmd_arg_q, cmd_arg_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic byte_accept;
  logic timer_enable;
  logic timer_expired;
  logic code_illegal;

  // Bytes are consumed only while a frame is being collected; in ISSUE they are dropped.
  assign byte_accept  = rx_done && (state_q != ISSUE);
  assign timer_enable = (state_q == WAIT_ARG) || (state_q == WAIT_CHK);
  // The upper nibble of CMD must be zero even though only [3:0] is routed out.
  assign code_illegal = (cmd_byte_q[7:4] != 4'h0) || (int'(cmd_byte_q[3:0]) >= NUM_CMDS);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (byte_accept),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Frame FSM next-state and output computation.
  always_comb begin
    state_d     = state_q;
    cmd_byte_d  = cmd_byte_q;
    arg_byte_d  = arg_byte_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    cmd_arg_d   = cmd_arg_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      WAIT_CMD: begin
        if (rx_done) begin
          if (rx_error) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LINE;
          end else begin
            cmd_byte_d = rx_data;
            state_d    = WAIT_ARG;
          end
        end
      end
      WAIT_ARG: begin
        if (rx_done) begin
          if (rx_error) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LINE;
            state_d     = WAIT_CMD;
          end else begin
            arg_byte_d = rx_data;
            state_d    = WAIT_CHK;
          end
        end else if (timer_expired) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = WAIT_CMD;
        end
      end
      WAIT_CHK: begin
        if (rx_done) begin
          state_d = WAIT_CMD;
          if (rx_error) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LINE;
          end else if (rx_data != frame_chk(cmd_byte_q, arg_byte_q)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
          end else if (code_illegal) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_UNKNOWN;
          end else begin
            cmd_code_d  = cmd_byte_q[3:0];
            cmd_arg_d   = arg_byte_q;
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
          end
        end else if (timer_expired) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = WAIT_CMD;
        end
      end
      ISSUE: begin
        if (rx_done && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_CMD;
        end
      end
      default: begin
        state_d = WAIT_CMD;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_CMD;
      cmd_byte_q  <= '0;
      arg_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_arg_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_LINE;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_byte_q  <= cmd_byte_d;
      arg_byte_q  <= arg_byte_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_arg_q   <= cmd_arg_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder. The stimulus process pushes the expected
// command/error event (with the clock edge that must produce it) into a queue;
// a monitor pops and compares whenever the DUT presents a command or an error.
module tb_uart_cmd_decoder;

  localparam int TIMEOUT = 20;
  localparam int NCMDS   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    bit         is_err;
    logic [3:0] code;
    logic [7:0] arg;
    logic [1:0] ecode;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  uart_cmd_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .NUM_CMDS      (NCMDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_error (rx_error),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code (cmd_code),
    .cmd_arg  (cmd_arg),
    .err_pulse(err_pulse),
    .err_code (err_code),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge number n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected events are stamped with the edge that samples the causing byte:
  // results are registered on that edge and seen by the monitor right after it.
  task automatic push_cmd(input logic [3:0] code, input logic [7:0] arg, input int c);
    exp_t e;
    e.is_err = 1'b0; e.code = code; e.arg = arg; e.ecode = 2'b00; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] ecode, input int c);
    exp_t e;
    e.is_err = 1'b1; e.code = 4'h0; e.arg = 8'h00; e.ecode = ecode; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; the byte is sampled on the next posedge (edge cyc+1).
  // Returns at the following negedge, so consecutive calls are back-to-back.
  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_data  = b;
    rx_done  = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every presented command/error against the scoreboard.
  initial begin
    exp_t       e;
    bit         prev_valid;
    logic [3:0] held_code;
    logic [7:0] held_arg;
    bit         held_ok;
    prev_valid = 1'b0;
    held_ok    = 1'b0;
    held_code  = 4'h0;
    held_arg   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (cmd_valid && !prev_valid) begin
          $display("[TB] cmd edge=%0d code=%0h arg=%02h", cyc, cmd_code, cmd_arg);
          if (exp_q.size() == 0) begin
            check("unexpected_cmd", {28'd0, cmd_code}, 32'hFFFF_FFFF);
            held_ok = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("cmd_kind", {31'd0, e.is_err}, 32'd0);
            check("cmd_code", {28'd0, cmd_code}, {28'd0, e.code});
            check("cmd_arg", {24'd0, cmd_arg}, {24'd0, e.arg});
            check("cmd_edge", cyc, e.cyc);
            held_code = e.code;
            held_arg  = e.arg;
            held_ok   = 1'b1;
          end
        end else if (cmd_valid && held_ok) begin
          check("hold_code", {28'd0, cmd_code}, {28'd0, held_code});
          check("hold_arg", {24'd0, cmd_arg}, {24'd0, held_arg});
        end
        if (err_pulse) begin
          $display("[TB] err edge=%0d code=%0d", cyc, err_code);
          if (exp_q.size() == 0) begin
            check("unexpected_err", {30'd0, err_code}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("err_kind", {31'd0, e.is_err}, 32'd1);
            check("err_code", {30'd0, err_code}, {30'd0, e.ecode});
            check("err_edge", cyc, e.cyc);
          end
        end
        prev_valid = cmd_valid;
      end
    end
  end

  // Stimulus.
  initial begin
    int c0;
    rst_n = 1'b0;
    idle(3);
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_code", {28'd0, cmd_code}, 32'd0);
    check("rst_arg", {24'd0, cmd_arg}, 32'd0);
    check("rst_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_ecode", {30'd0, err_code}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, back-to-back bytes: 03 ^ 5A = 59.
    send_byte(8'h03, 1'b0);
    send_byte(8'h5A, 1'b0);
    push_cmd(4'h3, 8'h5A, cyc + 1);
    send_byte(8'h59, 1'b0);
    idle(3);

    // Bad checksum, then a good frame recovers.
    send_byte(8'h03, 1'b0);
    send_byte(8'h5A, 1'b0);
    push_err(2'b10, cyc + 1);
    send_byte(8'h00, 1'b0);
    idle(3);
    check("ecode_held_chk", {30'd0, err_code}, 32'd2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    push_cmd(4'h1, 8'h10, cyc + 1);
    send_byte(8'h11, 1'b0);
    idle(3);

    // Unknown code (9 >= 8), nonzero upper nibble, checksum beats code check.
    send_byte(8'h09, 1'b0);
    send_byte(8'h00, 1'b0);
    push_err(2'b01, cyc + 1);
    send_byte(8'h09, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    push_err(2'b01, cyc + 1);
    send_byte(8'h13, 1'b0);
    send_byte(8'h09, 1'b0);
    send_byte(8'h00, 1'b0);
    push_err(2'b10, cyc + 1);
    send_byte(8'h00, 1'b0);
    idle(3);

    // Gap timeout: CMD at edge c0, nothing follows, error on edge c0+19.
    c0 = cyc + 1;
    push_err(2'b11, c0 + TIMEOUT - 1);
    send_byte(8'h02, 1'b0);
    idle(25);
    check("ecode_timeout", {30'd0, err_code}, 32'd3);
    // ARG lands exactly on edge c0+19: accepted, no timeout.
    send_byte(8'h02, 1'b0);
    idle(TIMEOUT - 2);
    send_byte(8'h44, 1'b0);
    push_cmd(4'h2, 8'h44, cyc + 1);
    send_byte(8'h46, 1'b0);
    // WAIT_CMD never times out; rx_error without rx_done is ignored.
    rx_error = 1'b1;
    idle(1);
    rx_error = 1'b0;
    idle(40);
    check("ecode_held_idle", {30'd0, err_code}, 32'd3);

    // Line error on the ARG byte aborts the frame.
    send_byte(8'h01, 1'b0);
    push_err(2'b00, cyc + 1);
    send_byte(8'h55, 1'b1);
    idle(3);
    check("ecode_line", {30'd0, err_code}, 32'd0);
    send_byte(8'h07, 1'b0);
    send_byte(8'hFF, 1'b0);
    push_cmd(4'h7, 8'hFF, cyc + 1);
    send_byte(8'hF8, 1'b0);
    idle(3);

    // Stalled consumer: bytes are dropped and counted, outputs hold.
    cmd_ready = 1'b0;
    send_byte(8'h05, 1'b0);
    send_byte(8'hA5, 1'b0);
    push_cmd(4'h5, 8'hA5, cyc + 1);
    send_byte(8'hA0, 1'b0);
    idle(2);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("drop_3", {24'd0, drop_cnt}, 32'd3);
    check("stall_valid", {31'd0, cmd_valid}, 32'd1);
    // Handshake with a byte on the same edge: byte dropped, valid falls.
    cmd_ready = 1'b1;
    send_byte(8'h7E, 1'b0);
    check("valid_fall", {31'd0, cmd_valid}, 32'd0);
    check("drop_hs", {24'd0, drop_cnt}, 32'd4);
    send_byte(8'h06, 1'b0);
    send_byte(8'h01, 1'b0);
    push_cmd(4'h6, 8'h01, cyc + 1);
    send_byte(8'h07, 1'b0);
    idle(3);
    // Saturation.
    cmd_ready = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    push_cmd(4'h2, 8'h03, cyc + 1);
    send_byte(8'h01, 1'b0);
    idle(1);
    for (int i = 0; i < 300; i++) send_byte(8'hC3, 1'b0);
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    cmd_ready = 1'b1;
    idle(3);

    // Leave err_code nonzero, stop in WAIT_CHK, then reset asynchronously.
    send_byte(8'h09, 1'b0);
    send_byte(8'h00, 1'b0);
    push_err(2'b01, cyc + 1);
    send_byte(8'h09, 1'b0);
    idle(2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("mid_rst_code", {28'd0, cmd_code}, 32'd0);
    check("mid_rst_arg", {24'd0, cmd_arg}, 32'd0);
    check("mid_rst_pulse", {31'd0, err_pulse}, 32'd0);
    check("mid_rst_ecode", {30'd0, err_code}, 32'd0);
    check("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    // Partial frame gone: a fresh frame decodes cleanly.
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    push_cmd(4'h4, 8'h01, cyc + 1);
    send_byte(8'h05, 1'b0);
    idle(5);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
